// File: rtl/fpu_pkg.sv
// Shared floating-point types for the bfloat16 datapath: operand class enum,
// BF16 field widths, canonical quiet NaN and the unpacked-operand struct.
package fpu_pkg;

  localparam int unsigned BF16_EXP_WIDTH  = 8;
  localparam int unsigned BF16_FRAC_WIDTH = 7;
  localparam int unsigned BF16_WIDTH      = 1 + BF16_EXP_WIDTH + BF16_FRAC_WIDTH;

  localparam logic [BF16_WIDTH-1:0] BF16_QNAN = 16'h7FC0;

  typedef enum logic [1:0] {
    FP_NORM = 2'd0,
    FP_ZERO = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic                       sign;
    logic [BF16_EXP_WIDTH-1:0]  exp;
    logic [BF16_FRAC_WIDTH-1:0] frac;
  } bf16_fields_t;

endpackage

// File: rtl/bf16_classify.sv
// Combinational classifier for one packed operand {sign,exp,frac}.
// Denormals (exp==0, frac!=0) are reported as zero (flush-to-zero).
// Ports:
//   i_op       packed operand, width 1+EXP_WIDTH+FRAC_WIDTH
//   o_class_c  operand class (combinational)
module bf16_classify
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = BF16_EXP_WIDTH,
  parameter int unsigned FRAC_WIDTH = BF16_FRAC_WIDTH,
  localparam int unsigned W         = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic [W-1:0] i_op,
  output fp_class_e    o_class_c
);

  logic [EXP_WIDTH-1:0]  w_exp;
  logic [FRAC_WIDTH-1:0] w_frac;
  logic                  w_unused_sign;

  assign w_exp         = i_op[W-2 -: EXP_WIDTH];
  assign w_frac        = i_op[FRAC_WIDTH-1:0];
  // Class does not depend on the sign.
  assign w_unused_sign = i_op[W-1];

  always_comb begin
    o_class_c = FP_NORM;
    if (w_exp == '0) begin
      o_class_c = FP_ZERO;
    end else if (w_exp == '1) begin
      o_class_c = (w_frac == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/bf16_add_operand_stage.sv
// Registered issue stage in front of the bfloat16 adder core. Unpacks both
// operands, applies the subtract sign flip to op2, resolves IEEE special cases
// into a bypass result, and buffers pairs in a 2-entry skid (main + skid).
// Optional macro BF16_OPSTAGE_STATS_EN adds saturating output-transfer counters.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          input handshake (in_ready registered)
//   in_op1, in_op2, in_sub     packed operands, 1 = op1 - op2
//   in_tag                     opaque tag, carried in order
//   out_valid/out_ready        output handshake
//   out_op{1,2}_{sign,exp,frac} unpacked fields (op2 sign effective)
//   out_bypass, out_bypass_val special-case result
//   out_tag                    tag
//   stat_total/bypass/nan      transfer counters (BF16_OPSTAGE_STATS_EN only)
module bf16_add_operand_stage
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_WIDTH  = BF16_EXP_WIDTH,
  parameter int unsigned FRAC_WIDTH = BF16_FRAC_WIDTH,
  parameter int unsigned TAG_WIDTH  = 4,
`ifdef BF16_OPSTAGE_STATS_EN
  parameter int unsigned CNT_WIDTH  = 16,
`endif
  localparam int unsigned W         = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_op1,
  input  logic [W-1:0]          in_op2,
  input  logic                  in_sub,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_op1_sign,
  output logic                  out_op2_sign,
  output logic [EXP_WIDTH-1:0]  out_op1_exp,
  output logic [EXP_WIDTH-1:0]  out_op2_exp,
  output logic [FRAC_WIDTH-1:0] out_op1_frac,
  output logic [FRAC_WIDTH-1:0] out_op2_frac,
  output logic                  out_bypass,
  output logic [W-1:0]          out_bypass_val,
  output logic [TAG_WIDTH-1:0]  out_tag
`ifdef BF16_OPSTAGE_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_total,
  output logic [CNT_WIDTH-1:0]  stat_bypass,
  output logic [CNT_WIDTH-1:0]  stat_nan
`endif
);

  localparam logic [W-1:0] QNAN = W'({1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}});

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [FRAC_WIDTH-1:0] frac;
  } op_t;

  typedef struct packed {
    op_t                  op1;
    op_t                  op2;
    logic                 bypass;
    logic                 is_nan;
    logic [W-1:0]         bypass_val;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  entry_t    r_main, r_skid, w_in_entry;
  logic      r_main_valid, r_skid_valid, r_in_ready;
  op_t       w_op1, w_op2;
  fp_class_e w_cls1, w_cls2;
  logic      w_accept, w_drain;
  logic      w_main_valid_nxt, w_skid_valid_nxt;
  logic      w_load_main_in, w_load_main_skid, w_load_skid;

  // Effective operands: subtraction becomes addition of the negated op2.
  assign w_op1 = op_t'(in_op1);
  assign w_op2 = op_t'({in_op2[W-1] ^ in_sub, in_op2[W-2:0]});

  bf16_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_cls1 (
    .i_op      (w_op1),
    .o_class_c (w_cls1)
  );

  bf16_classify #(.EXP_WIDTH(EXP_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_cls2 (
    .i_op      (w_op2),
    .o_class_c (w_cls2)
  );

  // Special-case resolution, first match wins.
  always_comb begin
    w_in_entry            = '0;
    w_in_entry.op1        = w_op1;
    w_in_entry.op2        = w_op2;
    w_in_entry.tag        = in_tag;
    if (w_cls1 == FP_NAN || w_cls2 == FP_NAN ||
        (w_cls1 == FP_INF && w_cls2 == FP_INF && w_op1.sign != w_op2.sign)) begin
      w_in_entry.bypass     = 1'b1;
      w_in_entry.is_nan     = 1'b1;
      w_in_entry.bypass_val = QNAN;
    end else if (w_cls1 == FP_INF) begin
      w_in_entry.bypass     = 1'b1;
      w_in_entry.bypass_val = w_op1;
    end else if (w_cls2 == FP_INF) begin
      w_in_entry.bypass     = 1'b1;
      w_in_entry.bypass_val = w_op2;
    end else if (w_cls1 == FP_ZERO && w_cls2 == FP_ZERO) begin
      w_in_entry.bypass     = 1'b1;
      w_in_entry.bypass_val = {w_op1.sign & w_op2.sign, {(W-1){1'b0}}};
    end else if (w_cls1 == FP_ZERO) begin
      w_in_entry.bypass     = 1'b1;
      w_in_entry.bypass_val = w_op2;
    end else if (w_cls2 == FP_ZERO) begin
      w_in_entry.bypass     = 1'b1;
      w_in_entry.bypass_val = w_op1;
    end
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_main_valid & out_ready;

  // Skid control; in_ready is low exactly when skid holds an entry.
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (r_skid_valid) begin
      if (w_drain) begin
        w_load_main_skid = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid || w_drain) begin
        w_load_main_in   = 1'b1;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_load_skid      = 1'b1;
        w_skid_valid_nxt = 1'b1;
      end
    end else if (w_drain) begin
      w_main_valid_nxt = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      if (w_load_main_in) begin
        r_main <= w_in_entry;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
    end
  end

  assign in_ready       = r_in_ready;
  assign out_valid      = r_main_valid;
  assign out_op1_sign   = r_main.op1.sign;
  assign out_op2_sign   = r_main.op2.sign;
  assign out_op1_exp    = r_main.op1.exp;
  assign out_op2_exp    = r_main.op2.exp;
  assign out_op1_frac   = r_main.op1.frac;
  assign out_op2_frac   = r_main.op2.frac;
  assign out_bypass     = r_main.bypass;
  assign out_bypass_val = r_main.bypass_val;
  assign out_tag        = r_main.tag;

`ifdef BF16_OPSTAGE_STATS_EN
  logic [CNT_WIDTH-1:0] r_stat_total, r_stat_bypass, r_stat_nan;

  // Saturating counters of output transfers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_total  <= '0;
      r_stat_bypass <= '0;
      r_stat_nan    <= '0;
    end else if (w_drain) begin
      if (r_stat_total != '1) begin
        r_stat_total <= r_stat_total + CNT_WIDTH'(1);
      end
      if (r_main.bypass && r_stat_bypass != '1) begin
        r_stat_bypass <= r_stat_bypass + CNT_WIDTH'(1);
      end
      if (r_main.is_nan && r_stat_nan != '1) begin
        r_stat_nan <= r_stat_nan + CNT_WIDTH'(1);
      end
    end
  end

  assign stat_total  = r_stat_total;
  assign stat_bypass = r_stat_bypass;
  assign stat_nan    = r_stat_nan;
`endif

endmodule
